// File: rtl/uart_tx_serializer.sv
// UART transmit serializer driven by a 16x oversampling tick: start bit, DBIT data bits LSB first,
// optional even parity, then SB_TICK ticks of stop. Define UART_TX_PARITY_EN to insert the parity bit.
module uart_tx_serializer #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    // Tick counter must also reach SB_TICK-1 while in STOP.
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

    localparam logic [SW-1:0] S_ZERO      = SW'(0);
    localparam logic [SW-1:0] S_ONE       = SW'(1);
    localparam logic [SW-1:0] S_LAST      = SW'(15);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [2:0]    N_LAST      = 3'(DBIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [DBIT-1:0] v);
        return ^v;
    endfunction
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [2:0]      n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_d;
`endif

    // State and output registers; reset forces the line idle-high and abandons any frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= S_ZERO;
            n_q     <= 3'd0;
            b_q     <= {DBIT{1'b0}};
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic; counters only move on s_tick cycles.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    state_d = START;
                    b_d     = din;
                    s_d     = S_ZERO;
`ifdef UART_TX_PARITY_EN
                    par_d   = even_parity(din);
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        state_d = DATA;
                        s_d     = S_ZERO;
                        n_d     = 3'd0;
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = S_ZERO;
                        b_d = b_q >> 1;
                        if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end else begin
                    state_d = DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        state_d = STOP;
                        s_d     = S_ZERO;
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end else begin
                    state_d = PARITY;
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP_LAST) begin
                        state_d = IDLE;
                        s_d     = S_ZERO;
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = S_ZERO;
                n_d     = 3'd0;
            end
        endcase
    end

    // Registered outputs are computed from the next state so tx lags its cause by exactly one clock.
    always_comb begin
        done_d = (state_q == STOP) && s_tick && (s_q == S_STOP_LAST);
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE) || done_d;
    end

    assign tx           = tx_q;
    assign tx_busy      = busy_q;
    assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: a per-cycle frame model built from the bit list and
// tick count drives two instances (1 and 2 stop bits). Honors UART_TX_PARITY_EN when defined.
module tb_uart_tx_serializer;

    logic       clk;
    logic       reset;
    logic       s_tick;
    logic       tx_start0, tx_start1;
    logic [7:0] din;
    logic       tx0, busy0, done0;
    logic       tx1, busy1, done1;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int tick_mode = 0;
    int phase     = 0;

    uart_tx_serializer #(.DBIT(8), .SB_TICK(16)) u_dut0 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start0), .din(din),
        .tx(tx0), .tx_busy(busy0), .tx_done_tick(done0)
    );

    uart_tx_serializer #(.DBIT(8), .SB_TICK(32)) u_dut1 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start1), .din(din),
        .tx(tx1), .tx_busy(busy1), .tx_done_tick(done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick source: every 4 clocks (mode 0) or random roughly one clock in three (mode 1).
    initial begin
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            phase++;
            if (tick_mode == 0) s_tick = (phase % 4 == 0);
            else                s_tick = ($urandom_range(0, 2) == 0);
        end
    end

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) tx_start0 = v;
        else          tx_start1 = v;
    endtask

    // One frame on instance sel. Expected tx at a cycle is bit floor(ticks/16) of the frame, where
    // ticks counts s_tick cycles strictly after acceptance; done fires when ticks reaches the length.
    task automatic run_frame(input int sel, input logic [7:0] d, input bit first, input bit hold,
                             input logic [7:0] next_d, input int inject_at);
        logic exp_bits[0:11];
        int   nb, total, ticks, idx, sb;
        bit   done_seen, injected, inj_active;
        logic otx, obusy, odone, etx;
        sb = (sel == 0) ? 16 : 32;
        nb = 0;
        exp_bits[nb] = 1'b0; nb++;
        for (int i = 0; i < 8; i++) begin exp_bits[nb] = d[i]; nb++; end
`ifdef UART_TX_PARITY_EN
        exp_bits[nb] = ^d; nb++;
`endif
        exp_bits[nb] = 1'b1; nb++;
        total = 16 * (nb - 1) + sb;
        if (first) begin
            @(posedge clk); #1;
            din = d;
            set_start(sel, 1'b1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        set_start(sel, hold);
        din = hold ? next_d : 8'($urandom);
        ticks = 0; done_seen = 0; injected = 0; inj_active = 0;
        for (int cyc = 0; cyc < 6000 && !done_seen; cyc++) begin
            @(negedge clk);
            otx   = (sel == 0) ? tx0   : tx1;
            obusy = (sel == 0) ? busy0 : busy1;
            odone = (sel == 0) ? done0 : done1;
            idx = ticks / 16;
            if (idx > nb - 1) idx = nb - 1;
            etx = exp_bits[idx];
            total_cnt++;
            if (otx !== etx) begin
                bad_cnt++;
                $display("FAIL frame_tx sel=%0d din=%h tick=%0d got=%b exp=%b", sel, d, ticks, otx, etx);
            end
            total_cnt++;
            if (obusy !== 1'b1) begin
                bad_cnt++;
                $display("FAIL frame_busy sel=%0d din=%h tick=%0d got=%b exp=1", sel, d, ticks, obusy);
            end
            total_cnt++;
            if (odone !== (ticks == total)) begin
                bad_cnt++;
                $display("FAIL frame_done sel=%0d din=%h tick=%0d got=%b exp=%b", sel, d, ticks, odone, (ticks == total));
            end
            if (ticks == total) done_seen = 1;
            else if (s_tick) ticks++;
            if (!done_seen) begin
                @(posedge clk); #1;
                if (inj_active) begin
                    set_start(sel, 1'b0);
                    inj_active = 0;
                end else if (inject_at >= 0 && !injected && ticks >= inject_at) begin
                    set_start(sel, 1'b1);
                    din = 8'hFF;
                    injected = 1;
                    inj_active = 1;
                end
            end
        end
        if (!done_seen) begin
            total_cnt++;
            bad_cnt++;
            $display("FAIL frame_timeout sel=%0d din=%h got=no_done exp=done", sel, d);
        end
        if (!hold) begin
            @(posedge clk); #1;
            @(negedge clk);
            otx   = (sel == 0) ? tx0   : tx1;
            obusy = (sel == 0) ? busy0 : busy1;
            odone = (sel == 0) ? done0 : done1;
            total_cnt++;
            if (otx !== 1'b1 || obusy !== 1'b0 || odone !== 1'b0) begin
                bad_cnt++;
                $display("FAIL post_idle sel=%0d din=%h got=tx%b/busy%b/done%b exp=tx1/busy0/done0",
                         sel, d, otx, obusy, odone);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; tx_start0 = 1'b0; tx_start1 = 1'b0; din = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin
            bad_cnt++;
            $display("FAIL reset0 got=tx%b/busy%b/done%b exp=tx1/busy0/done0", tx0, busy0, done0);
        end
        total_cnt++;
        if (tx1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
            bad_cnt++;
            $display("FAIL reset1 got=tx%b/busy%b/done%b exp=tx1/busy0/done0", tx1, busy1, done1);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        tick_mode = 0;
        run_frame(0, 8'hA5, 1, 0, 8'h00, -1);
    endtask

    task automatic test_parity();
        tick_mode = 0;
        run_frame(0, 8'h07, 1, 0, 8'h00, -1);
        run_frame(0, 8'h03, 1, 0, 8'h00, -1);
    endtask

    task automatic test_ignored();
        tick_mode = 0;
        run_frame(0, 8'h00, 1, 0, 8'h00, 40);
        run_frame(0, 8'h00, 1, 0, 8'h00, 150);
    endtask

    task automatic test_back_to_back();
        tick_mode = 0;
        run_frame(0, 8'h55, 1, 1, 8'hAA, -1);
        run_frame(0, 8'hAA, 0, 0, 8'h00, -1);
    endtask

    task automatic test_two_stop();
        tick_mode = 0;
        run_frame(1, 8'h81, 1, 0, 8'h00, -1);
    endtask

    task automatic test_reset_mid();
        tick_mode = 0;
        @(posedge clk); #1;
        din = 8'($urandom);
        tx_start0 = 1'b1;
        @(posedge clk); #1;
        tx_start0 = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        total_cnt++;
        if (busy0 !== 1'b1) begin
            bad_cnt++;
            $display("FAIL mid_busy_before got=%b exp=1", busy0);
        end
        reset = 1'b1;
        #1;
        total_cnt++;
        if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin
            bad_cnt++;
            $display("FAIL mid_reset got=tx%b/busy%b/done%b exp=tx1/busy0/done0", tx0, busy0, done0);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total_cnt++;
            if (done0 !== 1'b0 || tx0 !== 1'b1) begin
                bad_cnt++;
                $display("FAIL mid_hold got=tx%b/done%b exp=tx1/done0", tx0, done0);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        run_frame(0, 8'h3C, 1, 0, 8'h00, -1);
    endtask

    task automatic test_random();
        logic [7:0] a, b;
        int sel;
        tick_mode = 1;
        for (int k = 0; k < 6; k++) begin
            sel = $urandom_range(0, 1);
            a = 8'($urandom);
            b = 8'($urandom);
            if (k % 3 == 0) begin
                run_frame(sel, a, 1, 1, b, -1);
                run_frame(sel, b, 0, 0, 8'h00, -1);
            end else begin
                run_frame(sel, a, 1, 0, 8'h00, (k % 2 == 0) ? 70 : -1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_ignored();
        test_back_to_back();
        test_two_stop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
